shift_arbiter: RTL

Shares one shift datapath (the codebase's `sll`, `srl` and `sra` shifters, N=32) between two requesters. The requesters use valid/ready handshakes, and the block arbitrates between them round-robin. Each accepted request is shifted and captured in a one-deep output register with its requester ID. It sits between the ALU/branch issue logic and writeback, so the area cost of the 32-way mux shifters is paid once instead of per requester.

---
 rtl/shift_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one sll/srl/sra shift datapath between two requesters.
// Latency: 1 cycle from accept edge to resp_valid with the shifted result.
// Backpressure: one-deep output slot; both readys drop while the slot is full and resp_ready is low.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   reqK_valid/ready/in/shamt/op       requester K handshake and payload (K = 0, 1)
//                                      op: 00 sll, 01 srl, 10 sra, 11 pass-through
//   resp_valid/ready/out/id            result slot handshake, shifted data, issuing requester
//   done0_cnt, done1_cnt               saturating count of delivered responses per requester

// Logical left barrel shifter, one stage per shift-amount bit.
module shift_sll #(
  parameter  int N  = 32,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic [N-1:0]  y
);
  logic [N-1:0] acc;

  always_comb begin
    acc = a;
    for (int s = 0; s < SW; s++) begin
      if (shamt[s]) acc = acc << (1 << s);
    end
    y = acc;
  end
endmodule

// Logical right barrel shifter, zero fill.
module shift_srl #(
  parameter  int N  = 32,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic [N-1:0]  y
);
  logic [N-1:0] acc;

  always_comb begin
    acc = a;
    for (int s = 0; s < SW; s++) begin
      if (shamt[s]) acc = acc >> (1 << s);
    end
    y = acc;
  end
endmodule

// Arithmetic right barrel shifter, fills with the operand's top bit.
module shift_sra #(
  parameter  int N  = 32,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic [N-1:0]  y
);
  logic signed [N-1:0] acc;

  always_comb begin
    acc = $signed(a);
    for (int s = 0; s < SW; s++) begin
      if (shamt[s]) acc = acc >>> (1 << s);
    end
    y = acc;
  end
endmodule

module shift_arbiter #(
  parameter  int N     = 32,
  parameter  int CNT_W = 16,
  localparam int SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_in,
  input  logic [SW-1:0]    req0_shamt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_in,
  input  logic [SW-1:0]    req1_shamt,
  input  logic [1:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N-1:0]     resp_out,
  output logic             resp_id,
  output logic [CNT_W-1:0] done0_cnt,
  output logic [CNT_W-1:0] done1_cnt
);
  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef struct packed {
    logic [N-1:0]  dat;
    logic [SW-1:0] shamt;
    op_e           op;
  } req_t;

  req_t       req0_dat;
  req_t       req1_dat;
  req_t       sel_dat;

  logic       last_grant;
  logic       gnt_vld;
  logic       gnt_id;
  logic       slot_free;
  logic       accept;
  logic       deliver;

  logic [N-1:0] sll_y;
  logic [N-1:0] srl_y;
  logic [N-1:0] sra_y;
  logic [N-1:0] shift_dat;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign req0_dat = '{dat: req0_in, shamt: req0_shamt, op: op_e'(req0_op)};
  assign req1_dat = '{dat: req1_in, shamt: req1_shamt, op: op_e'(req1_op)};

  // Round-robin pick: a lone requester always wins; under contention the
  // side that was not served last wins. last_grant only moves on accept, so
  // stalled cycles never rotate priority.
  always_comb begin
    gnt_vld = req0_valid || req1_valid;
    gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = !last_grant;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign slot_free = !resp_valid || resp_ready;

  // rst_n gates the readys so nothing is offered while reset is held, even
  // though the emptied slot would otherwise look free.
  assign accept     = rst_n && slot_free && gnt_vld;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept &&  gnt_id;

  assign deliver = resp_valid && resp_ready;

  // Single shared datapath: only the granted payload reaches the shifters.
  assign sel_dat = gnt_id ? req1_dat : req0_dat;

  shift_sll #(.N(N)) u_sll (.a(sel_dat.dat), .shamt(sel_dat.shamt), .y(sll_y));
  shift_srl #(.N(N)) u_srl (.a(sel_dat.dat), .shamt(sel_dat.shamt), .y(srl_y));
  shift_sra #(.N(N)) u_sra (.a(sel_dat.dat), .shamt(sel_dat.shamt), .y(sra_y));

  always_comb begin
    shift_dat = sel_dat.dat;
    case (sel_dat.op)
      OP_SLL:  shift_dat = sll_y;
      OP_SRL:  shift_dat = srl_y;
      OP_SRA:  shift_dat = sra_y;
      OP_PASS: shift_dat = sel_dat.dat;
      default: shift_dat = sel_dat.dat;
    endcase
  end

  // Output slot and arbitration history. A delivery and an accept in the
  // same cycle simply reload the slot, so resp_valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_out   <= '0;
      resp_id    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        resp_valid <= 1'b1;
        resp_out   <= shift_dat;
        resp_id    <= gnt_id;
        last_grant <= gnt_id;
      end else if (deliver) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // Delivery counters credit the requester of the result leaving the slot,
  // not the one being accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done0_cnt <= '0;
      done1_cnt <= '0;
    end else if (deliver) begin
      if (!resp_id && done0_cnt != CNT_MAX) done0_cnt <= done0_cnt + 1'b1;
      if ( resp_id && done1_cnt != CNT_MAX) done1_cnt <= done1_cnt + 1'b1;
    end
  end
endmodule
